// File: rtl/gun_bullet_ctrl.sv
// gun_bullet_ctrl: single-bullet projectile FSM with a 2-cycle pixel pipeline matched to the gun sprite.
// Optional trail rendering behind the bullet when BULLET_TRAIL_EN is defined.
module gun_bullet_ctrl #(
   parameter int GUN_X0          = 730,
   parameter int MUZZLE_DX       = 2,
   parameter int MUZZLE_DY       = 10,
   parameter int BULLET_W        = 8,
   parameter int BULLET_H        = 4,
   parameter int STEP_FRAMES     = 2,
   parameter int STEP_PX         = 4,
   parameter int COOLDOWN_FRAMES = 30,
   parameter int TRAIL_LEN       = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] lcd_xpos,
   input  logic [11:0] lcd_ypos,
   input  logic        enable,
   input  logic        freeze,
   input  logic        fire,
   input  logic [11:0] gun_pos_y,
   input  logic        hit,
   output logic [23:0] bullet_pixel,
   output logic        pixel_valid,
   output logic        bullet_active,
   output logic [11:0] bullet_x,
   output logic [11:0] bullet_y
);
   typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} state_t;
   state_t state_q, state_d;
   logic [11:0] bullet_x_q, bullet_x_d, bullet_y_q, bullet_y_d;
   logic [15:0] step_cnt_q, step_cnt_d, cd_cnt_q, cd_cnt_d;
   logic [12:0] dx_q, dy_q;
   logic [23:0] bullet_pixel_q, bullet_pixel_d;
   logic        fire_q, fly1_q, pixel_valid_q, body, trail;
   logic        frame_tick, fire_rise;

   if (STEP_FRAMES < 1 || STEP_PX < 1 || TRAIL_LEN < 0) begin : g_param_check
      $error("gun_bullet_ctrl: STEP_FRAMES and STEP_PX must be >= 1, TRAIL_LEN >= 0");
   end

   assign frame_tick = (lcd_xpos == 12'd0) && (lcd_ypos == 12'd0);
   assign fire_rise  = fire && !fire_q;

   always_comb begin
      state_d    = state_q;
      bullet_x_d = bullet_x_q;
      bullet_y_d = bullet_y_q;
      step_cnt_d = step_cnt_q;
      cd_cnt_d   = cd_cnt_q;
      if (!enable) begin
         state_d    = IDLE;
         step_cnt_d = '0;
         cd_cnt_d   = '0;
      end else if (!freeze) begin
         case (state_q)
            IDLE: if (fire_rise) begin
               state_d    = FLYING;
               bullet_x_d = 12'(GUN_X0 + MUZZLE_DX - BULLET_W);
               bullet_y_d = gun_pos_y + 12'(MUZZLE_DY);
               step_cnt_d = '0;
            end
            // hit wins over a step or edge retire on the same cycle
            FLYING: if (hit) begin
               state_d  = COOLDOWN;
               cd_cnt_d = '0;
            end else if (frame_tick) begin
               if (step_cnt_q == 16'(STEP_FRAMES - 1)) begin
                  step_cnt_d = '0;
                  if (bullet_x_q < 12'(STEP_PX)) begin
                     state_d  = COOLDOWN;
                     cd_cnt_d = '0;
                  end else bullet_x_d = bullet_x_q - 12'(STEP_PX);
               end else step_cnt_d = step_cnt_q + 16'd1;
            end
            COOLDOWN: if (frame_tick) begin
               state_d  = (cd_cnt_q == 16'(COOLDOWN_FRAMES - 1)) ? IDLE : COOLDOWN;
               cd_cnt_d = (cd_cnt_q == 16'(COOLDOWN_FRAMES - 1)) ? 16'd0 : cd_cnt_q + 16'd1;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      body = fly1_q && enable && !dx_q[12] && (dx_q[11:0] < 12'(BULLET_W))
             && !dy_q[12] && (dy_q[11:0] < 12'(BULLET_H));
`ifdef BULLET_TRAIL_EN
      trail = fly1_q && enable && !dx_q[12] && (dx_q[11:0] >= 12'(BULLET_W))
              && (dx_q[11:0] < 12'(BULLET_W + TRAIL_LEN)) && !dy_q[12]
              && (dy_q[11:0] != 12'd0) && (dy_q[11:0] < 12'(BULLET_H - 1));
`else
      trail = 1'b0;
`endif
      bullet_pixel_d = body ? 24'h1F3A04 : (trail ? 24'h141E02 : 24'h0);
   end

   always_ff @(posedge clk) begin
      fire_q <= fire;
      if (rst) begin
         state_q        <= IDLE;
         bullet_x_q     <= '0;
         bullet_y_q     <= '0;
         step_cnt_q     <= '0;
         cd_cnt_q       <= '0;
         dx_q           <= '0;
         dy_q           <= '0;
         fly1_q         <= 1'b0;
         bullet_pixel_q <= '0;
         pixel_valid_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         bullet_x_q     <= bullet_x_d;
         bullet_y_q     <= bullet_y_d;
         step_cnt_q     <= step_cnt_d;
         cd_cnt_q       <= cd_cnt_d;
         dx_q           <= {1'b0, lcd_xpos} - {1'b0, bullet_x_q};
         dy_q           <= {1'b0, lcd_ypos} - {1'b0, bullet_y_q};
         fly1_q         <= (state_q == FLYING) && enable;
         bullet_pixel_q <= bullet_pixel_d;
         pixel_valid_q  <= body || trail;
      end
   end

   assign bullet_pixel  = bullet_pixel_q;
   assign pixel_valid   = pixel_valid_q;
   assign bullet_active = (state_q == FLYING);
   assign bullet_x      = bullet_x_q;
   assign bullet_y      = bullet_y_q;
endmodule

// File: tb/tb_gun_bullet_ctrl.sv
// tb_gun_bullet_ctrl: directed vector tables plus hand-written sequences for gun_bullet_ctrl.
module tb_gun_bullet_ctrl;
   logic        clk = 1'b0;
   logic        rst, enable, freeze, fire, hit;
   logic [11:0] lcd_xpos, lcd_ypos, gun_pos_y;
   logic [23:0] bullet_pixel;
   logic        pixel_valid, bullet_active;
   logic [11:0] bullet_x, bullet_y;
   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [11:0] x;
      logic [11:0] y;
      logic        v;
      logic [23:0] p;
   } vec_t;
   vec_t tab_a[7];
   vec_t tab_b[7];

`ifdef BULLET_TRAIL_EN
   localparam bit TR = 1'b1;
`else
   localparam bit TR = 1'b0;
`endif
   localparam logic [23:0] BODY = 24'h1F3A04;
   localparam logic [23:0] TRAILC = TR ? 24'h141E02 : 24'h0;

   gun_bullet_ctrl dut (
      .clk(clk), .rst(rst), .lcd_xpos(lcd_xpos), .lcd_ypos(lcd_ypos),
      .enable(enable), .freeze(freeze), .fire(fire), .gun_pos_y(gun_pos_y),
      .hit(hit), .bullet_pixel(bullet_pixel), .pixel_valid(pixel_valid),
      .bullet_active(bullet_active), .bullet_x(bullet_x), .bullet_y(bullet_y)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         lcd_xpos = 12'd0;
         lcd_ypos = 12'd0;
         step();
         lcd_xpos = 12'd100;
         lcd_ypos = 12'd100;
         step();
      end
   endtask

   task automatic pulse_fire();
      fire = 1'b1;
      step();
      fire = 1'b0;
      step();
   endtask

   task automatic run_table(input string name, input vec_t t[7]);
      for (int i = 0; i < 7; i++) begin
         lcd_xpos = t[i].x;
         lcd_ypos = t[i].y;
         step();
         lcd_xpos = 12'd100;
         lcd_ypos = 12'd100;
         step();
         chk($sformatf("%s[%0d].valid", name, i), 32'(pixel_valid), 32'(t[i].v));
         chk($sformatf("%s[%0d].pixel", name, i), 32'(bullet_pixel), 32'(t[i].p));
      end
   endtask

   initial begin
      tab_a[0] = '{12'd724, 12'd230, 1'b1, BODY};
      tab_a[1] = '{12'd731, 12'd233, 1'b1, BODY};
      tab_a[2] = '{12'd727, 12'd232, 1'b1, BODY};
      tab_a[3] = '{12'd732, 12'd230, 1'b0, 24'h0};
      tab_a[4] = '{12'd723, 12'd230, 1'b0, 24'h0};
      tab_a[5] = '{12'd724, 12'd234, 1'b0, 24'h0};
      tab_a[6] = '{12'd724, 12'd229, 1'b0, 24'h0};
      tab_b[0] = '{12'd700, 12'd230, 1'b1, BODY};
      tab_b[1] = '{12'd707, 12'd233, 1'b1, BODY};
      tab_b[2] = '{12'd708, 12'd231, TR, TRAILC};
      tab_b[3] = '{12'd713, 12'd232, TR, TRAILC};
      tab_b[4] = '{12'd708, 12'd230, 1'b0, 24'h0};
      tab_b[5] = '{12'd714, 12'd231, 1'b0, 24'h0};
      tab_b[6] = '{12'd708, 12'd233, 1'b0, 24'h0};

      rst = 1'b1; enable = 1'b1; freeze = 1'b0; fire = 1'b0; hit = 1'b0;
      lcd_xpos = 12'd100; lcd_ypos = 12'd100; gun_pos_y = 12'd220;
      step(); step();
      rst = 1'b0;
      step();
      chk("reset.active", 32'(bullet_active), 32'd0);
      chk("reset.x", 32'(bullet_x), 32'd0);
      chk("reset.y", 32'(bullet_y), 32'd0);
      chk("reset.valid", 32'(pixel_valid), 32'd0);
      chk("reset.pixel", 32'(bullet_pixel), 32'd0);

      fire = 1'b1;
      step();
      chk("spawn.active", 32'(bullet_active), 32'd1);
      chk("spawn.x", 32'(bullet_x), 32'd724);
      chk("spawn.y", 32'(bullet_y), 32'd230);
      fire = 1'b0;
      gun_pos_y = 12'd300;
      run_table("scan724", tab_a);

      tick(1);
      chk("move.half", 32'(bullet_x), 32'd724);
      tick(1);
      chk("move.step", 32'(bullet_x), 32'd720);
      tick(10);
      chk("move.x700", 32'(bullet_x), 32'd700);
      chk("move.yfixed", 32'(bullet_y), 32'd230);
      run_table("scan700", tab_b);

      pulse_fire();
      chk("fly.fire_drop", 32'(bullet_x), 32'd700);
      freeze = 1'b1;
      tick(10);
      pulse_fire();
      chk("freeze.x", 32'(bullet_x), 32'd700);
      chk("freeze.active", 32'(bullet_active), 32'd1);
      freeze = 1'b0;

      tick(350);
      chk("edge.x0", 32'(bullet_x), 32'd0);
      chk("edge.still", 32'(bullet_active), 32'd1);
      tick(2);
      chk("edge.retire", 32'(bullet_active), 32'd0);
      chk("edge.xhold", 32'(bullet_x), 32'd0);
      tick(29);
      pulse_fire();
      chk("cool.t29_fire", 32'(bullet_active), 32'd0);
      tick(1);
      pulse_fire();
      chk("cool.respawn", 32'(bullet_active), 32'd1);
      chk("cool.respawn_x", 32'(bullet_x), 32'd724);
      chk("cool.respawn_y", 32'(bullet_y), 32'd310);

      tick(113);
      chk("hit.pre_x", 32'(bullet_x), 32'd500);
      lcd_xpos = 12'd0; lcd_ypos = 12'd0; hit = 1'b1;
      step();
      hit = 1'b0; lcd_xpos = 12'd100; lcd_ypos = 12'd100;
      chk("hit.retire", 32'(bullet_active), 32'd0);
      chk("hit.xhold", 32'(bullet_x), 32'd500);
      tick(30);

      pulse_fire();
      chk("en.spawn", 32'(bullet_active), 32'd1);
      lcd_xpos = 12'd724; lcd_ypos = 12'd310;
      step(); step();
      chk("en.valid_before", 32'(pixel_valid), 32'd1);
      enable = 1'b0;
      step();
      chk("en.idle", 32'(bullet_active), 32'd0);
      chk("en.valid_off", 32'(pixel_valid), 32'd0);
      lcd_xpos = 12'd100; lcd_ypos = 12'd100;
      pulse_fire();
      chk("en.fire_ignored", 32'(bullet_active), 32'd0);
      enable = 1'b1;
      step();
      chk("en.reenable", 32'(bullet_active), 32'd0);

      freeze = 1'b1;
      pulse_fire();
      chk("freeze.idle_fire", 32'(bullet_active), 32'd0);
      freeze = 1'b0;
      step();
      chk("freeze.idle_after", 32'(bullet_active), 32'd0);
      pulse_fire();
      chk("refire.active", 32'(bullet_active), 32'd1);

      fire = 1'b1;
      step();
      rst = 1'b1;
      step();
      chk("rst.active", 32'(bullet_active), 32'd0);
      chk("rst.x", 32'(bullet_x), 32'd0);
      chk("rst.y", 32'(bullet_y), 32'd0);
      chk("rst.valid", 32'(pixel_valid), 32'd0);
      rst = 1'b0;
      step(); step();
      chk("rst.held_fire", 32'(bullet_active), 32'd0);
      fire = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/gun_bullet_ctrl.md
Name: gun_bullet_ctrl

Overview:
- Projectile stage directly downstream of the gun sprite generator. Consumes the gun's vertical position (`pos_y`) and the same LCD scan coordinates.
- On a fire request, spawns a single bullet at the gun muzzle and moves it leftward once per N frames. Retires it on screen edge or on an external hit.
- Renders the bullet as a pixel stream (`bullet_pixel`/`pixel_valid`), latency-matched to the gun sprite, for the downstream compositor and collision logic.

Parameters:
- GUN_X0, 730: gun sprite left x; must equal the gun block's FIG_X0.
- MUZZLE_DX, 2: muzzle x offset from GUN_X0.
- MUZZLE_DY, 10: muzzle y offset from gun_pos_y.
- BULLET_W, 8: bullet width in px.
- BULLET_H, 4: bullet height in px.
- STEP_FRAMES, 2: frame ticks between moves (>=1).
- STEP_PX, 4: px moved per step (>=1).
- COOLDOWN_FRAMES, 30: frame ticks after retire before a new fire is accepted.
- TRAIL_LEN, 6: trail length in px (only with BULLET_TRAIL_EN).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous reset, active-high.
- lcd_xpos  in  12  current scan x.
- lcd_ypos  in  12  current scan y.
- enable  in  1  block enable; low forces IDLE and no pixels.
- freeze  in  1  holds motion, counters and FSM; fire is ignored.
- fire  in  1  level from debounced button; rising edge detected internally.
- gun_pos_y  in  12  gun top y, from the gun block's pos_y.
- hit  in  1  one-cycle pulse from collision logic; retires the bullet.
- bullet_pixel  out  24  RGB565 packed as {3'b0,R,2'b0,G,3'b0,B}.
- pixel_valid  out  1  bullet_pixel is opaque for this coordinate.
- bullet_active  out  1  high in state FLYING.
- bullet_x  out  12  bullet left x.
- bullet_y  out  12  bullet top y.

Behaviour:
- Reset (rst sampled high on clk edge) drives every output and internal register to 0 and sets state IDLE, with one exception: fire_d, the fire edge register, is loaded with the current fire value so a button held through reset does not fire.
- frame_tick = (lcd_xpos==0 && lcd_ypos==0), evaluated combinationally on the current inputs.
- fire_rise = fire && !fire_d; fire_d updates every cycle.
- IDLE:
  - On fire_rise && enable && !freeze, the next edge loads bullet_x = GUN_X0+MUZZLE_DX-BULLET_W (724 with defaults) and bullet_y = gun_pos_y+MUZZLE_DY.
  - The same edge clears step_cnt and moves to FLYING.
- FLYING, on each frame_tick (when not frozen):
  - step_cnt increments.
  - When step_cnt == STEP_FRAMES-1: step_cnt clears; if bullet_x < STEP_PX, go to COOLDOWN; else bullet_x -= STEP_PX.
  - bullet_y is fixed after spawn; it does not follow the gun.
- FLYING with hit=1: go to COOLDOWN on the next edge. hit has priority over a same-cycle step or edge retire.
- COOLDOWN:
  - Counts frame ticks; after COOLDOWN_FRAMES ticks, go to IDLE.
  - fire_rise during COOLDOWN or FLYING is dropped, not queued.
- Ignored inputs: hit outside FLYING; fire and hit in the same cycle while IDLE resolve as a fire.
- freeze=1: state, position and all counters hold; fire_rise is ignored. fire_d still tracks fire.
- enable=0: next edge forces IDLE and clears counters; bullet_active=0; pixel_valid=0 from the next edge.
- Pixel pipeline, 2-cycle latency from lcd_xpos/lcd_ypos to bullet_pixel/pixel_valid:
  - Stage 1 registers dx = x - bullet_x and dy = y - bullet_y as 13-bit signed values.
  - Stage 2 registers the output. The pixel is inside when the state is FLYING and 0<=dx<BULLET_W and 0<=dy<BULLET_H.
  - Inside pixel: bullet_pixel = 24'h1F3A04 (R31,G58,B4) and pixel_valid=1.
  - Outside pixel: bullet_pixel = 0 and pixel_valid=0.
- bullet_x and bullet_y hold their last values after retire.

Optional Feature:
- Macro: BULLET_TRAIL_EN.
- When defined, pixels with BULLET_W<=dx<BULLET_W+TRAIL_LEN and 0<dy<BULLET_H-1 output 24'h141E02 (R20,G30,B2) with pixel_valid=1. The body has priority over the trail.
- When undefined, there is no trail logic and TRAIL_LEN is unused.

Test Plan:
- Spawn: gun_pos_y=220, fire 0->1 in IDLE -> 1 cycle later bullet_active=1, bullet_x=724, bullet_y=230; scan (724,230) gives pixel_valid=1 and 24'h1F3A04 two cycles later; (732,230) gives pixel_valid=0.
- Motion and edge retire:
  - 2 frame ticks -> bullet_x=720.
  - Continue to x=0; next step -> COOLDOWN and bullet_active=0.
  - fire_rise at COOLDOWN tick 29 is ignored; after tick 30, a fire_rise spawns again.
- Hit priority: hit pulse on the same cycle as a step tick at x=500 -> COOLDOWN, bullet_x stays 500.
- Freeze/enable:
  - freeze=1 for 10 frames mid-flight -> bullet_x unchanged and fire ignored.
  - enable=0 -> IDLE next edge, pixel_valid=0, later fire_rise with enable=0 ignored.
- Reset: rst=1 mid-flight with fire held high -> all outputs 0 and IDLE; releasing rst with fire still high does not fire.
- BULLET_TRAIL_EN: bullet at (700,230) -> (708,231) gives 24'h141E02, (708,230) gives pixel_valid=0, (714,231) gives pixel_valid=0.
